// File: rtl/uart_byte_receiver.sv
// ----------------------------------------------------------------------------
// uart_byte_receiver
//
// Purpose:
//    Upstream stage of the GPS receiver. Deserialises the asynchronous 8N1
//    serial line from the GPS module into bytes. Each good byte is presented
//    on `data` together with a one-cycle `load` strobe, which feed the
//    NMEA/GPZDA parser directly. A stop bit sampled low discards the byte,
//    pulses `frame_error`, and then waits for the line to return high, so that
//    a held-low (break) line is not decoded as a stream of 0x00 frames.
//    Short low glitches that do not last until the middle of the start bit
//    are rejected without any strobe.
//
// Parameters:
//    B             data bits per frame (LSB first, no parity, 1 stop bit)
//    ClocksPerBit  clock cycles per serial bit (>= 4)
//
// Ports:
//    clock        in   1  system clock
//    reset        in   1  synchronous, active-high reset
//    rx           in   1  raw serial line, idle high, asynchronous to clock
//    load         out  1  one-cycle strobe: `data` holds a newly received byte
//    data         out  B  last good byte, stable until the next `load`
//    frame_error  out  1  one-cycle strobe: stop bit sampled low, byte dropped
//    busy         out  1  high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_byte_receiver #(
   parameter int B            = 8,
   parameter int ClocksPerBit = 10417
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         rx,
   output logic         load,
   output logic [B-1:0] data,
   output logic         frame_error,
   output logic         busy
);

   localparam int CntW = $clog2(ClocksPerBit);
   localparam int IdxW = $clog2(B);

   // The start bit is checked half a bit in; every later sample is one full
   // bit after the previous one, which lands each sample on its bit centre.
   localparam logic [CntW-1:0] HalfLast = CntW'(ClocksPerBit / 2 - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(ClocksPerBit - 1);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(B - 1);

   typedef enum logic [2:0] {
      S_Idle,
      S_Start,
      S_Data,
      S_Stop,
      S_Break
   } state_t;

   state_t            state,       state_next;
   logic [CntW-1:0]   cnt,         cnt_next;
   logic [IdxW-1:0]   bit_idx,     bit_idx_next;
   logic [B-1:0]      shift,       shift_next;
   logic [B-1:0]      data_next;
   logic              load_next;
   logic              frame_error_next;

   logic              rx_meta;
   logic              rx_s;

   // Two-flop synchroniser for the asynchronous line. Both flops reset high
   // so that reset itself never looks like a falling edge / start bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // State and datapath registers. A reset mid-frame simply drops whatever
   // partial byte was in the shift register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_Idle;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         data        <= '0;
         load        <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         bit_idx     <= bit_idx_next;
         shift       <= shift_next;
         data        <= data_next;
         load        <= load_next;
         frame_error <= frame_error_next;
      end
   end

   // Next-state and strobe logic. The strobes default low so each one lasts a
   // single cycle; leaving S_Stop at the stop-bit centre lets a start bit that
   // follows immediately be caught with no idle gap.
   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      bit_idx_next     = bit_idx;
      shift_next       = shift;
      data_next        = data;
      load_next        = 1'b0;
      frame_error_next = 1'b0;

      case (state)
         S_Idle: begin
            if (!rx_s) begin
               state_next = S_Start;
               cnt_next   = '0;
            end
         end

         S_Start: begin
            if (cnt == HalfLast) begin
               cnt_next = '0;
               if (!rx_s) begin
                  state_next   = S_Data;
                  bit_idx_next = '0;
               end else begin
                  state_next = S_Idle;
               end
            end else begin
               cnt_next = cnt + CntW'(1);
            end
         end

         S_Data: begin
            if (cnt == BitLast) begin
               shift_next = {rx_s, shift[B-1:1]};
               cnt_next   = '0;
               if (bit_idx == IdxLast) begin
                  state_next = S_Stop;
               end else begin
                  bit_idx_next = bit_idx + IdxW'(1);
               end
            end else begin
               cnt_next = cnt + CntW'(1);
            end
         end

         S_Stop: begin
            if (cnt == BitLast) begin
               cnt_next = '0;
               if (rx_s) begin
                  load_next  = 1'b1;
                  data_next  = shift;
                  state_next = S_Idle;
               end else begin
                  frame_error_next = 1'b1;
                  state_next       = S_Break;
               end
            end else begin
               cnt_next = cnt + CntW'(1);
            end
         end

         S_Break: begin
            if (rx_s) begin
               state_next = S_Idle;
            end
         end

         default: begin
            state_next = S_Idle;
         end
      endcase
   end

   assign busy = (state != S_Idle);

endmodule
